// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: adds or subtracts two NIBBLES*4-bit two's-complement
// operands. One shared 4-bit ripple adder (adder4) handles one nibble per clock,
// least-significant nibble first.
// Optional feature: define ADDSUB_SAT_EN to saturate Result on signed overflow.
// Without it, Result wraps modulo 2^W and no saturation logic is built.

// 4-bit ripple-carry adder. It returns the carry out of bit 3 (c4) and the
// signed-overflow flag of the nibble (carry into bit 3 XOR carry out of bit 3).
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4,
  output logic       v
);

  logic [4:0] c;

  // Ripple the carry through four full-adder cells.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c0;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c4 = c[4];
    v  = c[4] ^ c[3];
  end

endmodule

module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Start,
  input  logic                 Sub,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 Busy,
  output logic                 Done,
  output logic [4*NIBBLES-1:0] Result,
  output logic                 Cout,
  output logic                 V
);

  localparam int W = 4 * NIBBLES;

  // The step counter is 3 bits wide, which covers NIBBLES up to 8.
  localparam logic [2:0] STEP_LAST = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         carry;
  logic [2:0]   step;
  logic [W-1:0] result_q;
  logic         cout_q;
  logic         v_q;

  logic [3:0]   sum;
  logic         c4;
  logic         ovf;
  logic         accept;
  logic         last_step;
  logic [W-1:0] sum_ext;
  logic [W-1:0] result_shift;
  logic [W-1:0] result_load;

`ifdef ADDSUB_SAT_EN
  // Sign of the latched A operand. It selects the saturation direction.
  logic         a_sign;
`endif

  // The single shared nibble adder.
  adder4 u_adder4 (
    .a  (op_a[3:0]),
    .b  (op_b[3:0]),
    .c0 (carry),
    .s  (sum),
    .c4 (c4),
    .v  (ovf)
  );

  // A new request is accepted only from IDLE or DONE.
  // The last step is the RUN cycle that handles the most-significant nibble.
  always_comb begin
    accept    = Start && ((state == IDLE) || (state == DONE));
    last_step = (state == RUN) && (step == STEP_LAST);
  end

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // Start is ignored in RUN, and DONE chains straight into a new RUN when Start is held.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (step == STEP_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Build the next Result value.
  // The new sum nibble enters at the top while older nibbles move down.
  // With saturation enabled, an overflow on the last step loads the clamp value instead.
  always_comb begin
    sum_ext      = '0;
    sum_ext[3:0] = sum;
    result_shift = (result_q >> 4) | (sum_ext << (W - 4));
    result_load  = result_shift;
`ifdef ADDSUB_SAT_EN
    if (last_step && ovf) begin
      if (a_sign) begin
        result_load = {1'b1, {(W - 1){1'b0}}};
      end else begin
        result_load = {1'b0, {(W - 1){1'b1}}};
      end
    end
`endif
  end

  // Datapath registers.
  // On accept: latch the operands. For a subtract, invert B and set the carry-in to 1.
  // On each RUN cycle: consume one nibble and shift the result in.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      step     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
`ifdef ADDSUB_SAT_EN
      a_sign   <= 1'b0;
`endif
    end else if (accept) begin
      op_a  <= A;
      op_b  <= Sub ? ~B : B;
      carry <= Sub;
      step  <= '0;
`ifdef ADDSUB_SAT_EN
      a_sign <= A[W-1];
`endif
    end else if (state == RUN) begin
      op_a     <= op_a >> 4;
      op_b     <= op_b >> 4;
      carry    <= c4;
      step     <= step + 3'd1;
      result_q <= result_load;
      if (last_step) begin
        cout_q <= c4;
        v_q    <= ovf;
      end
    end
  end

  // Status and result outputs.
  always_comb begin
    Busy   = (state == RUN);
    Done   = (state == DONE);
    Result = result_q;
    Cout   = cout_q;
    V      = v_q;
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Testbench for nibble_serial_addsub.
// It drives a 4-nibble instance and a 1-nibble instance, and checks both
// against a plain-arithmetic reference model.
module tb_nibble_serial_addsub;

  logic        clock;
  logic        resetn;

  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        v;

  logic        start1;
  logic        sub1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        busy1;
  logic        done1;
  logic [3:0]  result1;
  logic        cout1;
  logic        v1;

  int n_cmp;
  int n_err;

  nibble_serial_addsub #(.NIBBLES(4)) dut (
    .Clock  (clock),
    .Resetn (resetn),
    .Start  (start),
    .Sub    (sub),
    .A      (a),
    .B      (b),
    .Busy   (busy),
    .Done   (done),
    .Result (result),
    .Cout   (cout),
    .V      (v)
  );

  nibble_serial_addsub #(.NIBBLES(1)) dut1 (
    .Clock  (clock),
    .Resetn (resetn),
    .Start  (start1),
    .Sub    (sub1),
    .A      (a1),
    .B      (b1),
    .Busy   (busy1),
    .Done   (done1),
    .Result (result1),
    .Cout   (cout1),
    .V      (v1)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model for a w-bit operation, using ordinary integer arithmetic.
  function automatic void model(input int w, input int unsigned ia, input int unsigned ib,
                                input logic isub, output int unsigned r,
                                output logic co, output logic vo);
    int unsigned m;
    int unsigned raw;
    logic sa, sb, sr;
    m = 32'd1 << w;
    if (isub) begin
      raw = (ia + m - ib) % m;
      co  = (ia >= ib);
    end else begin
      raw = (ia + ib) % m;
      co  = ((ia + ib) >= m);
    end
    sa = ((ia  >> (w - 1)) & 1) != 0;
    sb = ((ib  >> (w - 1)) & 1) != 0;
    sr = ((raw >> (w - 1)) & 1) != 0;
    vo = isub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    r  = raw;
`ifdef ADDSUB_SAT_EN
    if (vo) r = sa ? (m >> 1) : ((m >> 1) - 1);
`endif
  endfunction

  // Run one operation on the 4-nibble instance with a single-cycle Start pulse.
  // Returns the number of Busy cycles seen, whether Done arrived, and the final outputs.
  task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                               output int busy_cnt, output logic got_done,
                               output logic [15:0] r, output logic co, output logic vo);
    int waited;
    waited = 0;
    @(negedge clock);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    busy_cnt = 0;
    while (!done && waited < 20) begin
      if (busy) busy_cnt++;
      waited++;
      @(negedge clock);
    end
    got_done = done;
    r = result; co = cout; vo = v;
  endtask

  // Run one operation on the 1-nibble instance.
  task automatic applyStimulus1(input logic [3:0] ia, input logic [3:0] ib, input logic isub,
                                output int busy_cnt, output logic got_done,
                                output logic [3:0] r, output logic co, output logic vo);
    int waited;
    waited = 0;
    @(negedge clock);
    a1 = ia; b1 = ib; sub1 = isub; start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    busy_cnt = 0;
    while (!done1 && waited < 20) begin
      if (busy1) busy_cnt++;
      waited++;
      @(negedge clock);
    end
    got_done = done1;
    r = result1; co = cout1; vo = v1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    n_cmp++;
    if ({busy, done, result, cout, v} !== 19'd0) begin
      n_err++;
      $display("[TB] FAIL reset4 got=%h required=0", {busy, done, result, cout, v});
    end
    n_cmp++;
    if ({busy1, done1, result1, cout1, v1} !== 7'd0) begin
      n_err++;
      $display("[TB] FAIL reset1 got=%h required=0", {busy1, done1, result1, cout1, v1});
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  // The directed vectors, each checked against literal expected values.
  task automatic test_directed();
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic        ts [4];
    logic [15:0] er [4];
    logic        ec [4];
    logic        ev [4];
    int bc;
    logic gd, co, vo;
    logic [15:0] r;
    ta = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
    tb = '{16'h1111, 16'h0001, 16'h0001, 16'h0001};
    ts = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
    er = '{16'h2345, 16'h0000, 16'h7FFF, 16'h8000};
`else
    er = '{16'h2345, 16'h0000, 16'h8000, 16'h7FFF};
`endif
    ec = '{1'b0, 1'b1, 1'b0, 1'b1};
    ev = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ta[i], tb[i], ts[i], bc, gd, r, co, vo);
      n_cmp++;
      if (!gd || bc != 4) begin
        n_err++;
        $display("[TB] FAIL dir%0d_timing done=%b busy=%0d required done=1 busy=4", i, gd, bc);
      end
      n_cmp++;
      if ({r, co, vo} !== {er[i], ec[i], ev[i]}) begin
        n_err++;
        $display("[TB] FAIL dir%0d got r=%h c=%b v=%b required r=%h c=%b v=%b",
                 i, r, co, vo, er[i], ec[i], ev[i]);
      end
    end
  endtask

  task automatic test_random();
    int bc;
    logic gd, co, vo, mc, mv;
    logic [15:0] r, ra, rb;
    logic rs;
    int unsigned mr;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      // Every fourth case places the operands near the sign boundary to exercise overflow.
      if (i % 4 == 0) begin
        ra[15:12] = 4'h7 + 4'($urandom_range(0, 1));
        rb[15:12] = 4'h7 + 4'($urandom_range(0, 1));
      end
      model(16, ra, rb, rs, mr, mc, mv);
      applyStimulus(ra, rb, rs, bc, gd, r, co, vo);
      n_cmp++;
      if (!gd || bc != 4) begin
        n_err++;
        $display("[TB] FAIL rand_timing done=%b busy=%0d required done=1 busy=4", gd, bc);
      end
      n_cmp++;
      if ({r, co, vo} !== {16'(mr), mc, mv}) begin
        n_err++;
        $display("[TB] FAIL rand a=%h b=%h s=%b got r=%h c=%b v=%b required r=%h c=%b v=%b",
                 ra, rb, rs, r, co, vo, 16'(mr), mc, mv);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    @(negedge clock);
    a = 16'h0005; b = 16'h0007; sub = 1'b1; start = 1'b1;
    w1 = 0;
    while (!done && w1 < 20) begin
      @(negedge clock);
      w1++;
      if (w1 == 1) begin a = 16'h0003; b = 16'h0003; end
    end
    n_cmp++;
    if (!done || {result, cout, v} !== {16'hFFFE, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL b2b_first done=%b got r=%h c=%b v=%b required r=fffe c=0 v=0",
               done, result, cout, v);
    end
    w2 = 0;
    do begin
      @(negedge clock);
      w2++;
      if (w2 == 1) start = 1'b0;
    end while (!done && w2 < 20);
    n_cmp++;
    if (w2 != 5) begin
      n_err++;
      $display("[TB] FAIL b2b_gap got=%0d required=5", w2);
    end
    n_cmp++;
    if ({result, cout, v} !== {16'h0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL b2b_second got r=%h c=%b v=%b required r=0 c=1 v=0", result, cout, v);
    end
  endtask

  task automatic test_ignore_start();
    int waited, bc;
    @(negedge clock);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waited = 0; bc = 0;
    while (!done && waited < 20) begin
      if (busy) bc++;
      if (waited == 1) begin
        start = 1'b1; a = 16'h4444; b = 16'h2222; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      waited++;
      @(negedge clock);
    end
    n_cmp++;
    if (!done || bc != 4 || {result, cout, v} !== {16'h2345, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL ignore_start done=%b busy=%0d got r=%h required r=2345 busy=4",
               done, bc, result);
    end
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ignore_start_queued busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    int bc, seen;
    logic gd, co, vo;
    logic [15:0] r;
    // Leave Cout=1 from an earlier operation so the reset has something to clear.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, bc, gd, r, co, vo);
    @(negedge clock);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, result, cout, v} !== 19'd0) begin
      n_err++;
      $display("[TB] FAIL reset_mid_run got=%h required=0", {busy, done, result, cout, v});
    end
    @(negedge clock);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("[TB] FAIL reset_no_done got=%0d required=0", seen);
    end
    applyStimulus(16'h0005, 16'h0007, 1'b1, bc, gd, r, co, vo);
    n_cmp++;
    if (!gd || bc != 4 || {r, co, vo} !== {16'hFFFE, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL after_reset done=%b busy=%0d got r=%h c=%b v=%b required r=fffe c=0 v=0",
               gd, bc, r, co, vo);
    end
  endtask

  // Exhaustive check of the single-nibble build, plus the listed 6+3 case.
  task automatic test_single_nibble();
    int bc;
    logic gd, co, vo, mc, mv;
    logic [3:0] r;
    int unsigned mr;
    applyStimulus1(4'h6, 4'h3, 1'b0, bc, gd, r, co, vo);
    n_cmp++;
`ifdef ADDSUB_SAT_EN
    if (!gd || bc != 1 || {r, co, vo} !== {4'h7, 1'b0, 1'b1}) begin
`else
    if (!gd || bc != 1 || {r, co, vo} !== {4'h9, 1'b0, 1'b1}) begin
`endif
      n_err++;
      $display("[TB] FAIL n1_6p3 done=%b busy=%0d got r=%h c=%b v=%b", gd, bc, r, co, vo);
    end
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          model(4, x, y, 1'(s), mr, mc, mv);
          applyStimulus1(4'(x), 4'(y), 1'(s), bc, gd, r, co, vo);
          n_cmp++;
          if (!gd || bc != 1 || {r, co, vo} !== {4'(mr), mc, mv}) begin
            n_err++;
            $display("[TB] FAIL n1 a=%h b=%h s=%0d busy=%0d got r=%h c=%b v=%b required r=%h c=%b v=%b",
                     x, y, s, bc, r, co, vo, 4'(mr), mc, mv);
          end
        end
      end
    end
  endtask

  // Watchdog that guarantees the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence.
  initial begin
    n_cmp = 0; n_err = 0;
    start = 0; sub = 0; a = '0; b = '0;
    start1 = 0; sub1 = 0; a1 = '0; b1 = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_single_nibble();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
